// File: rtl/nes_pad_array.sv
// Polls up to four NES controllers in parallel once per frame and reports
// the held button state plus press/release edges between consecutive polls.
module nes_pad_array #(
  parameter int NUM_PADS     = 2,
  parameter int CLK_DIV      = 150,
  parameter int LATCH_CYCLES = 300
) (
  input  logic                  pixelClock,
  input  logic                  reset,
  input  logic                  vSyncStart,
  input  logic [NUM_PADS-1:0]   padEnable,
  input  logic [NUM_PADS-1:0]   padData,
  output logic                  padLatch,
  output logic                  padPulse,
  output logic [8*NUM_PADS-1:0] buttons,
  output logic [8*NUM_PADS-1:0] pressed,
  output logic [8*NUM_PADS-1:0] released,
  output logic                  frameValid,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  // One counter serves every phase, so it is sized for the longest one.
  localparam int MAX_CNT = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);

  state_t                    state, stateNext;
  logic [CNT_W-1:0]          cnt, cntNext;
  logic [3:0]                bitIdx, bitIdxNext;
  logic                      sampleNow;
  logic [NUM_PADS-1:0][7:0]  shiftReg;
  logic [8*NUM_PADS-1:0]     newButtons;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    bitIdxNext = bitIdx;
    sampleNow  = 1'b0;
    case (state)
      IDLE: begin
        if (vSyncStart) begin
          stateNext = LATCH;
          cntNext   = '0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          stateNext  = LOW;
          cntNext    = '0;
          bitIdxNext = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      LOW: begin
        if (cnt == DIV_LAST) begin
          sampleNow  = 1'b1;
          bitIdxNext = bitIdx + 1'b1;
          cntNext    = '0;
          stateNext  = (bitIdx == 4'd7) ? DONE : HIGH;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (cnt == DIV_LAST) begin
          stateNext = LOW;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Pad data is active-low; a disabled pad reads as nothing pressed.
  always_comb begin
    newButtons = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      newButtons[8*p +: 8] = padEnable[p] ? ~shiftReg[p] : 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      padLatch   <= 1'b0;
      padPulse   <= 1'b0;
      busy       <= 1'b0;
      frameValid <= 1'b0;
      buttons    <= '0;
      pressed    <= '0;
      released   <= '0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      bitIdx     <= bitIdxNext;
      // Line outputs follow the next state so they stay aligned with it.
      padLatch   <= (stateNext == LATCH);
      padPulse   <= (stateNext == HIGH);
      busy       <= (stateNext != IDLE);
      frameValid <= (state == DONE);
      if (sampleNow) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          shiftReg[p] <= {shiftReg[p][6:0], padData[p]};
        end
      end
      if (state == DONE) begin
        buttons  <= newButtons;
        pressed  <= newButtons & ~buttons;
        released <= ~newButtons & buttons;
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_array.sv
// Directed bench for nes_pad_array: a behavioural two-pad controller model,
// a table of frames with hand-computed results, and reset corner sequences.
module tb_nes_pad_array;

  logic        pixelClock = 1'b0;
  logic        reset;
  logic        vSyncStart;
  logic [1:0]  padEnable;
  logic [1:0]  padData;
  logic        padLatch;
  logic        padPulse;
  logic [15:0] buttons;
  logic [15:0] pressed;
  logic [15:0] released;
  logic        frameValid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 pixelClock = ~pixelClock;

  nes_pad_array #(.NUM_PADS(2), .CLK_DIV(150), .LATCH_CYCLES(300)) dut (
    .pixelClock(pixelClock),
    .reset     (reset),
    .vSyncStart(vSyncStart),
    .padEnable (padEnable),
    .padData   (padData),
    .padLatch  (padLatch),
    .padPulse  (padPulse),
    .buttons   (buttons),
    .pressed   (pressed),
    .released  (released),
    .frameValid(frameValid),
    .busy      (busy)
  );

  // Controller model: latch loads the held buttons (A first), each rising
  // pulse shifts the next button out; the line is active-low.
  logic [7:0] held [2];
  logic [7:0] sr   [2];
  logic       prevPulse = 1'b0;

  initial begin
    held[0] = 8'h00; held[1] = 8'h00;
    sr[0]   = 8'h00; sr[1]   = 8'h00;
  end

  always @(negedge pixelClock) begin
    for (int p = 0; p < 2; p++) begin
      if (padLatch) sr[p] = held[p];
      else if (padPulse && !prevPulse) sr[p] = {sr[p][6:0], 1'b0};
    end
    prevPulse = padPulse;
  end

  assign padData = {~sr[1][7], ~sr[0][7]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  held0;
    logic [7:0]  held1;
    logic [1:0]  en;
    logic [15:0] expButtons;
    logic [15:0] expPressed;
    logic [15:0] expReleased;
  } frame_t;

  frame_t vec [6];

  // One full poll with a stray vSyncStart at cycle 1000, padEnable inverted
  // between cycles 1000 and 2000, and a vSyncStart landing in DONE.
  task automatic runPoll(input string tag, input frame_t f);
    int cycles, latchCnt, pulses, run, minW, maxW, busyHigh;
    logic prev;
    held[0] = f.held0;
    held[1] = f.held1;
    padEnable = f.en;
    @(negedge pixelClock);
    vSyncStart = 1'b1;
    @(posedge pixelClock);
    #1;
    vSyncStart = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    cycles = 0; latchCnt = 32'(padLatch); pulses = 0; run = 0;
    minW = 9999; maxW = 0; prev = padPulse;
    while (cycles < 3000) begin
      @(posedge pixelClock);
      #1;
      cycles++;
      vSyncStart = 1'b0;
      if (frameValid) break;
      if (padLatch) latchCnt++;
      if (padPulse && !prev) pulses++;
      if (padPulse) run++;
      else if (run > 0) begin
        if (run < minW) minW = run;
        if (run > maxW) maxW = run;
        run = 0;
      end
      prev = padPulse;
      if (cycles == 1000) begin
        vSyncStart = 1'b1;
        padEnable  = ~f.en;
      end
      if (cycles == 2000) padEnable = f.en;
      if (cycles == 2550) vSyncStart = 1'b1;
    end
    vSyncStart = 1'b0;
    check({tag, "_latency"},   32'(cycles),   32'd2551);
    check({tag, "_buttons"},   32'(buttons),  32'(f.expButtons));
    check({tag, "_pressed"},   32'(pressed),  32'(f.expPressed));
    check({tag, "_released"},  32'(released), 32'(f.expReleased));
    check({tag, "_latch_len"}, 32'(latchCnt), 32'd300);
    check({tag, "_pulses"},    32'(pulses),   32'd7);
    check({tag, "_pulse_min"}, 32'(minW),     32'd150);
    check({tag, "_pulse_max"}, 32'(maxW),     32'd150);
    check({tag, "_overlap"},   32'(pressed & released), 32'd0);
    busyHigh = 0;
    @(posedge pixelClock);
    #1;
    check({tag, "_fv_width"}, 32'(frameValid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (busy) busyHigh++;
      @(posedge pixelClock);
      #1;
    end
    check({tag, "_no_restart"}, 32'(busyHigh), 32'd0);
  endtask

  initial begin
    int fvCount, busyCount;
    vec[0] = '{8'h81, 8'h00, 2'b11, 16'h0081, 16'h0081, 16'h0000};
    vec[1] = '{8'h01, 8'h00, 2'b11, 16'h0001, 16'h0000, 16'h0080};
    vec[2] = '{8'h10, 8'h10, 2'b01, 16'h0010, 16'h0010, 16'h0001};
    vec[3] = '{8'h10, 8'h10, 2'b11, 16'h1010, 16'h1000, 16'h0000};
    vec[4] = '{8'hff, 8'h00, 2'b10, 16'h0000, 16'h0000, 16'h1010};
    vec[5] = '{8'hff, 8'h42, 2'b11, 16'h42ff, 16'h42ff, 16'h0000};

    reset = 1'b1;
    vSyncStart = 1'b0;
    padEnable = 2'b00;
    repeat (3) @(posedge pixelClock);
    #1;
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_latch",   32'(padLatch),   32'd0);
    check("rst_pulse",   32'(padPulse),   32'd0);
    check("rst_fv",      32'(frameValid), 32'd0);
    check("rst_buttons", 32'(buttons),    32'd0);
    check("rst_pressed", 32'(pressed),    32'd0);

    // vSyncStart coinciding with reset must not start a poll.
    @(negedge pixelClock);
    vSyncStart = 1'b1;
    @(posedge pixelClock);
    #1;
    reset = 1'b0;
    vSyncStart = 1'b0;
    @(posedge pixelClock);
    #1;
    check("rst_vsync_busy",  32'(busy),     32'd0);
    check("rst_vsync_latch", 32'(padLatch), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runPoll($sformatf("frame%0d", i), vec[i]);
    end

    // Reset at cycle 1200 of a poll aborts it completely.
    held[0] = 8'h81; held[1] = 8'h00; padEnable = 2'b11;
    @(negedge pixelClock);
    vSyncStart = 1'b1;
    @(posedge pixelClock);
    #1;
    vSyncStart = 1'b0;
    repeat (1200) @(posedge pixelClock);
    #1;
    reset = 1'b1;
    @(posedge pixelClock);
    #1;
    reset = 1'b0;
    check("midrst_latch",    32'(padLatch), 32'd0);
    check("midrst_pulse",    32'(padPulse), 32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_buttons",  32'(buttons),  32'd0);
    check("midrst_released", 32'(released), 32'd0);
    fvCount = 0; busyCount = 0;
    for (int i = 0; i < 2700; i++) begin
      @(posedge pixelClock);
      #1;
      if (frameValid) fvCount++;
      if (busy) busyCount++;
    end
    check("midrst_no_fv",   32'(fvCount),   32'd0);
    check("midrst_no_busy", 32'(busyCount), 32'd0);

    // First poll after reset reports every held button as pressed.
    runPoll("postrst", '{8'h81, 8'h00, 2'b11, 16'h0081, 16'h0081, 16'h0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
